// File: rtl/instr_register_exec.sv
// instr_register_exec: 32-entry instruction store that computes results at write time, with an iterative divider for DIV/MOD
// Optional feature: define INSTR_REG_FWD_EN to forward same-cycle writes onto instruction_word.
module instr_register_exec #(
    parameter int DEPTH     = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_en,
    input  logic signed [31:0]       operand_a,
    input  logic signed [31:0]       operand_b,
    input  logic [3:0]               opcode,
    input  logic [$clog2(DEPTH)-1:0] write_pointer,
    input  logic [$clog2(DEPTH)-1:0] read_pointer,
    output logic [135:0]             instruction_word,
    output logic                     busy,
    output logic [15:0]              drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DIV_ITERS) + 1;
    localparam logic [3:0] OP_PASSA = 4'd1, OP_PASSB = 4'd2, OP_ADD = 4'd3, OP_SUB = 4'd4,
                           OP_MULT = 4'd5, OP_DIV = 4'd6, OP_MOD = 4'd7;

    // pad keeps the word at 136 bits; it always reads as zero
    typedef struct packed {
        logic [3:0]  pad;
        logic [3:0]  opc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [63:0] res;
    } instruction_t;

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_WRITE} state_t;

    instruction_t        mem [DEPTH];
    state_t              state, state_nx;
    logic [3:0]          opc_q;
    logic [31:0]         a_q, b_q, quo, dvs, rem, rem_nx;
    logic [AW-1:0]       ptr_q;
    logic [CW-1:0]       cnt;
    logic                accept, start, single_we, ge;
    logic [32:0]         trial;
    logic signed [63:0]  a64, b64, res_single;
    logic [63:0]         q64, r64, wr_res;
    instruction_t        single_entry, wr_entry;

    assign busy      = state != S_IDLE;
    assign accept    = load_en && !busy;
    assign start     = accept && (opcode == OP_DIV || opcode == OP_MOD) && operand_b != 32'sd0;
    assign single_we = accept && !start;

    // single-cycle result, computed at 64 bits so nothing wraps; DIV/MOD by zero and unknown opcodes give 0
    always_comb begin
        a64 = {{32{operand_a[31]}}, operand_a};
        b64 = {{32{operand_b[31]}}, operand_b};
        res_single = opcode == OP_PASSA ? a64 :
                     opcode == OP_PASSB ? b64 :
                     opcode == OP_ADD   ? a64 + b64 :
                     opcode == OP_SUB   ? a64 - b64 :
                     opcode == OP_MULT  ? a64 * b64 : 64'sd0;
        single_entry = '{4'd0, opcode, operand_a, operand_b, res_single};
    end

    // one restoring step per cycle on magnitudes, then sign fix-up following SV truncating semantics
    always_comb begin
        trial  = {rem, quo[31]};
        ge     = trial >= {1'b0, dvs};
        rem_nx = ge ? 32'(trial - {1'b0, dvs}) : trial[31:0];
        q64    = {32'd0, quo};
        r64    = {32'd0, rem};
        wr_res = opc_q == OP_DIV ? ((a_q[31] ^ b_q[31]) ? -q64 : q64)
                                 : (a_q[31] ? -r64 : r64);
        wr_entry = '{4'd0, opc_q, a_q, b_q, wr_res};
    end

    // next-state: IDLE -> DIV on a nonzero-divisor divide, DIV for DIV_ITERS cycles, one WRITE cycle
    always_comb begin
        state_nx = state;
        state_nx = state == S_IDLE ? (start ? S_DIV : S_IDLE) :
                   state == S_DIV  ? (cnt == CW'(DIV_ITERS - 1) ? S_WRITE : S_DIV) : S_IDLE;
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // divider operands and working registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ptr_q <= '0;
            quo   <= '0;
            dvs   <= '0;
            rem   <= '0;
            cnt   <= '0;
        end else if (start) begin
            opc_q <= opcode;
            a_q   <= operand_a;
            b_q   <= operand_b;
            ptr_q <= write_pointer;
            quo   <= operand_a[31] ? 32'(-operand_a) : operand_a;
            dvs   <= operand_b[31] ? 32'(-operand_b) : operand_b;
            rem   <= '0;
            cnt   <= '0;
        end else if (state == S_DIV) begin
            quo <= {quo[30:0], ge};
            rem <= rem_nx;
            cnt <= cnt + 1'b1;
        end
    end

    // entry store; the divider's WRITE store is last so it wins a same-pointer collision
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (single_we) mem[write_pointer] <= single_entry;
            if (state == S_WRITE) mem[ptr_q] <= wr_entry;
        end
    end

    // saturating count of writes refused while busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                              drop_cnt <= '0;
        else if (load_en && busy && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end

    // combinational read port, optionally bypassing the value being stored this cycle
    always_comb begin
        instruction_word = mem[read_pointer];
`ifdef INSTR_REG_FWD_EN
        instruction_word = (state == S_WRITE && ptr_q == read_pointer) ? wr_entry :
                           (single_we && write_pointer == read_pointer) ? single_entry :
                           mem[read_pointer];
`else
        instruction_word = mem[read_pointer];
`endif
    end
endmodule

// File: tb/tb_instr_register_exec.sv
// tb_instr_register_exec: directed vector table plus hand sequences for divider timing, drops, mid-divide reset and forwarding
module tb_instr_register_exec;
    localparam logic [3:0] ZERO = 0, PASSA = 1, PASSB = 2, ADD = 3, SUB = 4, MULT = 5, DIV = 6, MOD = 7;

    logic         clk = 0, reset_n = 0, load_en = 0, busy;
    logic [31:0]  operand_a = 0, operand_b = 0;
    logic [3:0]   opcode = 0;
    logic [4:0]   write_pointer = 0, read_pointer = 0;
    logic [135:0] instruction_word;
    logic [15:0]  drop_cnt;
    int checks = 0, errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  p;
        logic [63:0] res;
        int          busy_cyc;
    } vec_t;
    vec_t vt[20];

    instr_register_exec dut (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .operand_a(operand_a),
        .operand_b(operand_b), .opcode(opcode), .write_pointer(write_pointer),
        .read_pointer(read_pointer), .instruction_word(instruction_word),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] p);
        @(negedge clk);
        load_en = 1; opcode = op; operand_a = a; operand_b = b; write_pointer = p;
        @(negedge clk);
        load_en = 0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic read_entry(input logic [4:0] p, output logic [135:0] w);
        read_pointer = p;
        #1 w = instruction_word;
    endtask

    initial begin
        logic [135:0] w;
        int n;
        vt[0]  = '{ADD,   -32'sd15, 32'sd7,   5'd3,  -64'sd8,  0};
        vt[1]  = '{MULT,  -32'sd5,  32'sd15,  5'd4,  -64'sd75, 0};
        vt[2]  = '{ZERO,  32'd5,    32'd6,    5'd0,  64'd0,    0};
        vt[3]  = '{PASSA, -32'sd12, 32'd99,   5'd1,  -64'sd12, 0};
        vt[4]  = '{PASSB, 32'd3,    -32'sd7,  5'd2,  -64'sd7,  0};
        vt[5]  = '{SUB,   32'h8000_0000, 32'd1, 5'd5, 64'hFFFF_FFFF_7FFF_FFFF, 0};
        vt[6]  = '{MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd6, 64'h3FFF_FFFF_0000_0001, 0};
        vt[7]  = '{ADD,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd8, 64'h0000_0000_FFFF_FFFE, 0};
        vt[8]  = '{DIV,   -32'sd15, 32'sd4,   5'd9,  -64'sd3,  33};
        vt[9]  = '{MOD,   -32'sd15, 32'sd4,   5'd10, -64'sd3,  33};
        vt[10] = '{DIV,   32'sd15,  -32'sd4,  5'd11, -64'sd3,  33};
        vt[11] = '{MOD,   32'sd15,  -32'sd4,  5'd12, 64'd3,    33};
        vt[12] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 64'h0000_0000_8000_0000, 33};
        vt[13] = '{MOD,   32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 64'd0, 33};
        vt[14] = '{DIV,   32'd100,  32'd0,    5'd15, 64'd0,    0};
        vt[15] = '{MOD,   32'd100,  32'd0,    5'd16, 64'd0,    0};
        vt[16] = '{4'd9,  32'd5,    32'd5,    5'd17, 64'd0,    0};
        vt[17] = '{DIV,   32'd7,    32'd7,    5'd18, 64'd1,    33};
        vt[18] = '{DIV,   32'd3,    32'd10,   5'd19, 64'd0,    33};
        vt[19] = '{MOD,   32'd3,    32'd10,   5'd20, 64'd3,    33};

        repeat (2) @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 32; i++) begin
            read_entry(5'(i), w);
            check($sformatf("reset_entry_%0d", i), w, 136'd0);
        end
        check("reset_busy", {135'd0, busy}, 136'd0);
        check("reset_drop_cnt", {120'd0, drop_cnt}, 136'd0);

        for (int i = 0; i < 20; i++) begin
            do_write(vt[i].op, vt[i].a, vt[i].b, vt[i].p);
            count_busy(n);
            check($sformatf("vec%0d_busy_cycles", i), 136'(n), 136'(vt[i].busy_cyc));
            read_entry(vt[i].p, w);
            check($sformatf("vec%0d_entry", i), w, {4'd0, vt[i].op, vt[i].a, vt[i].b, vt[i].res});
        end
        check("table_drop_cnt", {120'd0, drop_cnt}, 136'd0);

        do_write(DIV, 32'd100, 32'd7, 5'd21);
        for (int i = 0; i < 5; i++) begin
            load_en = 1; opcode = PASSA; operand_a = 32'd55; operand_b = 32'd0; write_pointer = 5'(22 + i);
            @(negedge clk);
        end
        load_en = 0;
        count_busy(n);
        check("drop_busy_cycles", 136'(n + 5), 136'd33);
        check("drop_cnt_5", {120'd0, drop_cnt}, 136'd5);
        for (int i = 22; i < 27; i++) begin
            read_entry(5'(i), w);
            check($sformatf("drop_entry_%0d", i), w, 136'd0);
        end
        read_entry(5'd21, w);
        check("drop_div_result", w, {4'd0, DIV, 32'd100, 32'd7, 64'd14});

        do_write(DIV, -32'sd15, 32'sd4, 5'd27);
        repeat (9) @(negedge clk);
        reset_n = 0;
        #1 check("midreset_busy", {135'd0, busy}, 136'd0);
        @(negedge clk);
        reset_n = 1;
        repeat (40) @(negedge clk);
        check("midreset_busy_stays_low", {135'd0, busy}, 136'd0);
        read_entry(5'd27, w);
        check("midreset_entry27", w, 136'd0);
        check("midreset_drop_cnt", {120'd0, drop_cnt}, 136'd0);
        do_write(ADD, 32'd1, 32'd2, 5'd27);
        read_entry(5'd27, w);
        check("after_reset_write", w, {4'd0, ADD, 32'd1, 32'd2, 64'd3});

        @(negedge clk);
        load_en = 1; opcode = PASSA; operand_a = 32'd12; operand_b = 32'd0; write_pointer = 5'd7; read_pointer = 5'd7;
        #1;
`ifdef INSTR_REG_FWD_EN
        check("fwd_same_cycle", instruction_word, {4'd0, PASSA, 32'd12, 32'd0, 64'd12});
`else
        check("fwd_same_cycle", instruction_word, 136'd0);
`endif
        @(negedge clk);
        load_en = 0;
        read_entry(5'd7, w);
        check("fwd_after_edge", w, {4'd0, PASSA, 32'd12, 32'd0, 64'd12});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
